// File: rtl/memory_stage.sv
// MEM pipeline stage: launches loads/stores on the req/ack data-memory port,
// flags misaligned and faulting accesses, and registers results into WB.
// Execute is held (MEM_STALL) from the accept cycle until the access completes.
//
// DMEM handshake: DMEM_REQ rises the cycle after an access is accepted and,
// together with DMEM_WE/ADDR/WDATA/WSTRB, stays constant until the cycle in
// which DMEM_ERR or DMEM_ACK is seen (ERR wins) or the wait counter expires.
// REQ drops at the following edge. ACK/ERR outside of WAIT are ignored.
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_V,
  input  logic [31:0] MEM_IR,
  input  logic [63:0] MEM_ALU_RESULT,
  input  logic [63:0] MEM_SR2,
  input  logic [63:0] MEM_NPC,
  input  logic [63:0] MEM_CSRFD,
  input  logic [63:0] MEM_RFD,
  input  logic [4:0]  MEM_DRID,
  input  logic        MEM_PC_MUX,
  input  logic        MEM_ECALL,
  input  logic        MEM_F_IAM,
  input  logic        MEM_F_IAF,
  input  logic        MEM_F_II,
  input  logic        MEM_FLUSH,
  output logic        MEM_STALL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [63:0] DMEM_ADDR,
  output logic [63:0] DMEM_WDATA,
  output logic [7:0]  DMEM_WSTRB,
  input  logic        DMEM_ACK,
  input  logic        DMEM_ERR,
  input  logic [63:0] DMEM_RDATA,
  output logic        WB_V,
  output logic [31:0] WB_IR,
  output logic [63:0] WB_NPC,
  output logic [63:0] WB_ALU_RESULT,
  output logic [63:0] WB_CSRFD,
  output logic [63:0] WB_RFD,
  output logic [4:0]  WB_DRID,
  output logic        WB_PC_MUX,
  output logic        WB_ECALL,
  output logic [63:0] WB_MEM_RESULT,
  output logic        WB_F_IAM,
  output logic        WB_F_IAF,
  output logic        WB_F_II,
  output logic        WB_LAM,
  output logic        WB_LAF,
  output logic        WB_SAM,
  output logic        WB_SAF,
  output logic        dbg_state
);

  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;
  localparam int   CNT_W = $clog2(TIMEOUT);

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic             flush_pend;

  // Access attributes captured at accept, used when the access completes.
  logic             op_load;
  logic [1:0]       op_size;
  logic             op_unsigned;
  logic [2:0]       op_lo;

  logic       is_load, is_store, suppress, misaligned, launch;
  logic [1:0] size;
  logic [2:0] lo;
  logic [7:0] size_mask;
  logic       timeout_hit, done, fault, capture;
  logic [63:0] lane, ld_data;

  assign is_load  = (MEM_IR[6:0] == 7'b0000011);
  assign is_store = (MEM_IR[6:0] == 7'b0100011);
  assign size     = MEM_IR[13:12];
  assign lo       = MEM_ALU_RESULT[2:0];
  assign suppress = MEM_ECALL | MEM_F_IAM | MEM_F_IAF | MEM_F_II;
  assign launch   = MEM_V & ~MEM_FLUSH & (is_load | is_store) & ~misaligned & ~suppress;

  // Natural-alignment test and byte-enable pattern for the access size.
  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (size)
      2'd1:    begin misaligned = lo[0];      size_mask = 8'h03; end
      2'd2:    begin misaligned = |lo[1:0];   size_mask = 8'h0F; end
      2'd3:    begin misaligned = |lo;        size_mask = 8'hFF; end
      default: begin misaligned = 1'b0;       size_mask = 8'h01; end
    endcase
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign done        = DMEM_ERR | DMEM_ACK | timeout_hit;
  // Meaningful only when done: an error, or expiry without an ACK.
  assign fault       = DMEM_ERR | ~DMEM_ACK;
  assign capture     = (state == IDLE) ? ~launch : done;

  assign MEM_STALL = (state == IDLE) ? launch : ~done;
  assign dbg_state = state;

  // Bring the addressed byte to lane 0, then truncate and extend to size.
  assign lane = DMEM_RDATA >> {op_lo, 3'b000};
  always_comb begin
    ld_data = lane;
    case (op_size)
      2'd0:    ld_data = op_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1:    ld_data = op_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2:    ld_data = op_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: ld_data = lane;
    endcase
  end

  // Access FSM: launches the DMEM request and holds it until completion.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      flush_pend  <= 1'b0;
      op_load     <= 1'b0;
      op_size     <= 2'd0;
      op_unsigned <= 1'b0;
      op_lo       <= 3'd0;
      DMEM_REQ    <= 1'b0;
      DMEM_WE     <= 1'b0;
      DMEM_ADDR   <= 64'd0;
      DMEM_WDATA  <= 64'd0;
      DMEM_WSTRB  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= WAIT;
            cnt         <= '0;
            flush_pend  <= 1'b0;
            op_load     <= is_load;
            op_size     <= size;
            op_unsigned <= MEM_IR[14];
            op_lo       <= lo;
            DMEM_REQ    <= 1'b1;
            DMEM_WE     <= is_store;
            DMEM_ADDR   <= {MEM_ALU_RESULT[63:3], 3'b000};
            DMEM_WDATA  <= is_store ? (MEM_SR2 << {lo, 3'b000}) : 64'd0;
            DMEM_WSTRB  <= is_store ? (size_mask << lo) : 8'd0;
          end
        end
        default: begin
          if (done) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
            DMEM_REQ   <= 1'b0;
            DMEM_WE    <= 1'b0;
            DMEM_ADDR  <= 64'd0;
            DMEM_WDATA <= 64'd0;
            DMEM_WSTRB <= 8'd0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // A flush cannot cancel the access; remember it to squash the result.
            if (MEM_FLUSH) flush_pend <= 1'b1;
          end
        end
      endcase
    end
  end

  // Writeback register: captures on the 1-cycle path or on access completion.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WB_V          <= 1'b0;
      WB_IR         <= 32'd0;
      WB_NPC        <= 64'd0;
      WB_ALU_RESULT <= 64'd0;
      WB_CSRFD      <= 64'd0;
      WB_RFD        <= 64'd0;
      WB_DRID       <= 5'd0;
      WB_PC_MUX     <= 1'b0;
      WB_ECALL      <= 1'b0;
      WB_MEM_RESULT <= 64'd0;
      WB_F_IAM      <= 1'b0;
      WB_F_IAF      <= 1'b0;
      WB_F_II       <= 1'b0;
      WB_LAM        <= 1'b0;
      WB_LAF        <= 1'b0;
      WB_SAM        <= 1'b0;
      WB_SAF        <= 1'b0;
    end else if (capture) begin
      WB_IR         <= MEM_IR;
      WB_NPC        <= MEM_NPC;
      WB_ALU_RESULT <= MEM_ALU_RESULT;
      WB_CSRFD      <= MEM_CSRFD;
      WB_RFD        <= MEM_RFD;
      WB_DRID       <= MEM_DRID;
      WB_PC_MUX     <= MEM_PC_MUX;
      WB_ECALL      <= MEM_ECALL;
      WB_F_IAM      <= MEM_F_IAM;
      WB_F_IAF      <= MEM_F_IAF;
      WB_F_II       <= MEM_F_II;
      if (state == IDLE) begin
        WB_V          <= MEM_V & ~MEM_FLUSH;
        WB_MEM_RESULT <= 64'd0;
        WB_LAM        <= MEM_V & is_load & misaligned & ~suppress;
        WB_SAM        <= MEM_V & is_store & misaligned & ~suppress;
        WB_LAF        <= 1'b0;
        WB_SAF        <= 1'b0;
      end else begin
        WB_V          <= ~(flush_pend | MEM_FLUSH);
        WB_MEM_RESULT <= (op_load & ~fault) ? ld_data : 64'd0;
        WB_LAM        <= 1'b0;
        WB_SAM        <= 1'b0;
        WB_LAF        <= op_load & fault;
        WB_SAF        <= ~op_load & fault;
      end
    end else begin
      WB_V <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: table of single-cycle vectors, directed multi-cycle
// sequences, and randomized transactions checked against a byte-level model.
module tb_memory_stage;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MEM_V = 1'b0;
  logic [31:0] MEM_IR = '0;
  logic [63:0] MEM_ALU_RESULT = '0, MEM_SR2 = '0, MEM_NPC = '0, MEM_CSRFD = '0, MEM_RFD = '0;
  logic [4:0]  MEM_DRID = '0;
  logic        MEM_PC_MUX = 1'b0, MEM_ECALL = 1'b0, MEM_F_IAM = 1'b0, MEM_F_IAF = 1'b0, MEM_F_II = 1'b0;
  logic        MEM_FLUSH = 1'b0;
  logic        MEM_STALL;
  logic        DMEM_REQ, DMEM_WE;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic        DMEM_ACK = 1'b0, DMEM_ERR = 1'b0;
  logic [63:0] DMEM_RDATA = '0;
  logic        WB_V, WB_PC_MUX, WB_ECALL;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_ALU_RESULT, WB_CSRFD, WB_RFD, WB_MEM_RESULT;
  logic [4:0]  WB_DRID;
  logic        WB_F_IAM, WB_F_IAF, WB_F_II, WB_LAM, WB_LAF, WB_SAM, WB_SAF;
  logic        dbg_state;

  memory_stage #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_IR(MEM_IR),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR2(MEM_SR2), .MEM_NPC(MEM_NPC),
    .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_DRID(MEM_DRID),
    .MEM_PC_MUX(MEM_PC_MUX), .MEM_ECALL(MEM_ECALL), .MEM_F_IAM(MEM_F_IAM),
    .MEM_F_IAF(MEM_F_IAF), .MEM_F_II(MEM_F_II), .MEM_FLUSH(MEM_FLUSH),
    .MEM_STALL(MEM_STALL), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_WSTRB(DMEM_WSTRB),
    .DMEM_ACK(DMEM_ACK), .DMEM_ERR(DMEM_ERR), .DMEM_RDATA(DMEM_RDATA),
    .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC), .WB_ALU_RESULT(WB_ALU_RESULT),
    .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD), .WB_DRID(WB_DRID), .WB_PC_MUX(WB_PC_MUX),
    .WB_ECALL(WB_ECALL), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_F_IAM(WB_F_IAM),
    .WB_F_IAF(WB_F_IAF), .WB_F_II(WB_F_II), .WB_LAM(WB_LAM), .WB_LAF(WB_LAF),
    .WB_SAM(WB_SAM), .WB_SAF(WB_SAF), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Observations from the last transaction.
  int          o_nreq, o_stall;
  logic        o_done, o_unstable, o_we;
  logic [63:0] o_addr, o_wdata;
  logic [7:0]  o_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd5, op};
  endfunction

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_AL = 7'b0010011;

  // ---------------- driver ----------------
  // Presents one instruction and plays the memory side until MEM_STALL drops.
  // flags = {ecall, f_iam, f_iaf, f_ii}; flush_at = WAIT cycle index for a flush pulse.
  task automatic run_txn(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] sr2,
                         input logic [63:0] rdata, input int delay, input logic err,
                         input logic noack, input logic xack, input int flush_at,
                         input logic flush0, input logic [3:0] flags);
    @(negedge CLK);
    MEM_V = 1'b1; MEM_IR = ir; MEM_ALU_RESULT = alu; MEM_SR2 = sr2;
    MEM_NPC = {$urandom, $urandom}; MEM_CSRFD = {$urandom, $urandom};
    MEM_RFD = {$urandom, $urandom}; MEM_DRID = 5'($urandom); MEM_PC_MUX = 1'($urandom);
    {MEM_ECALL, MEM_F_IAM, MEM_F_IAF, MEM_F_II} = flags;
    MEM_FLUSH = flush0; DMEM_ACK = 1'b0; DMEM_ERR = 1'b0;
    o_nreq = 0; o_stall = 0; o_done = 1'b0; o_unstable = 1'b0;
    for (int c = 0; c < 64 && !o_done; c++) begin
      if (c > 0) MEM_FLUSH = DMEM_REQ && (flush_at >= 0) && (o_nreq == flush_at);
      DMEM_RDATA = {$urandom, $urandom};
      if (DMEM_REQ) begin
        if (o_nreq == 0) begin
          o_addr = DMEM_ADDR; o_we = DMEM_WE; o_wdata = DMEM_WDATA; o_wstrb = DMEM_WSTRB;
        end else if (DMEM_ADDR !== o_addr || DMEM_WE !== o_we ||
                     DMEM_WDATA !== o_wdata || DMEM_WSTRB !== o_wstrb) begin
          o_unstable = 1'b1;
        end
        if (!noack && o_nreq == delay) begin
          DMEM_ERR = err; DMEM_ACK = !err || xack; DMEM_RDATA = rdata;
        end
        o_nreq++;
      end
      #1;
      if (MEM_STALL) o_stall++;
      else o_done = 1'b1;
      @(negedge CLK);
      DMEM_ACK = 1'b0; DMEM_ERR = 1'b0; MEM_FLUSH = 1'b0;
    end
    MEM_V = 1'b0;
    chk("complete", o_done, 1'b1);
    chk("dmem_held", o_unstable, 1'b0);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        access;
    logic [63:0] addr, wdata, res;
    logic        we, wb_v, lam, sam, laf, saf;
    logic [7:0]  wstrb;
    int          nreq;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ir, input logic [63:0] alu, input logic [63:0] sr2,
                                 input logic [63:0] rdata, input logic flush0, input logic flush_wait,
                                 input logic [3:0] flags, input int delay, input logic err,
                                 input logic noack);
    exp_t e;
    int n, off;
    logic ld, st, mis, sup, fault;
    logic [63:0] val;
    ld  = (ir[6:0] == OP_LD);
    st  = (ir[6:0] == OP_ST);
    n   = 1 << ir[13:12];
    off = int'(alu[2:0]);
    mis = (off % n) != 0;
    sup = |flags;
    e.access = !flush0 && (ld || st) && !mis && !sup;
    e.addr   = alu - 64'(off);
    e.we     = st;
    e.wdata  = sr2 << (8 * off);
    e.wstrb  = 8'd0;
    if (!mis) for (int i = 0; i < n; i++) e.wstrb[off + i] = 1'b1;
    e.nreq = !e.access ? 0 : (noack ? TIMEOUT : delay + 1);
    fault  = e.access && (err || noack);
    e.wb_v = !flush0 && !(e.access && flush_wait);
    val = 64'd0;
    if (e.access && ld && !fault) begin
      for (int i = 0; i < n; i++) val |= ((rdata >> (8 * (off + i))) & 64'hFF) << (8 * i);
      if (!ir[14] && n < 8 && val[8 * n - 1]) val = val - (64'd1 << (8 * n));
    end
    e.res = val;
    e.lam = ld && mis && !sup;
    e.sam = st && mis && !sup;
    e.laf = fault && ld;
    e.saf = fault && st;
    return e;
  endfunction

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    logic [31:0] ir;
    logic [63:0] alu;
    logic        v, flush, ecall, f_iaf;
    logic        exp_v, exp_lam, exp_sam;
  } vec_t;

  vec_t vecs[8];

  initial begin
    automatic exp_t e;
    automatic logic [31:0] ir;
    automatic logic [63:0] alu, sr2, rdata;
    automatic int delay, fa;
    automatic logic err, noack, xack, flush0;
    automatic logic [3:0] flags;

    vecs[0] = '{{12'd42, 5'd0, 3'd0, 5'd5, OP_AL}, 64'h2A, 1, 0, 0, 0, 1, 0, 0};
    vecs[1] = '{mk_ir(OP_LD, 3'd2), 64'h3002, 1, 0, 0, 0, 1, 1, 0};
    vecs[2] = '{mk_ir(OP_ST, 3'd3), 64'h3004, 1, 0, 0, 0, 1, 0, 1};
    vecs[3] = '{mk_ir(OP_LD, 3'd1), 64'h4001, 1, 0, 0, 0, 1, 1, 0};
    vecs[4] = '{mk_ir(OP_LD, 3'd3), 64'h5000, 1, 0, 1, 0, 1, 0, 0};
    vecs[5] = '{mk_ir(OP_ST, 3'd2), 64'h6000, 1, 0, 0, 1, 1, 0, 0};
    vecs[6] = '{mk_ir(OP_LD, 3'd0), 64'h6001, 1, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{mk_ir(OP_LD, 3'd2), 64'h7000, 0, 0, 0, 0, 0, 0, 0};

    // ---- reset state ----
    #12;
    chk("rst_req", DMEM_REQ, 1'b0);
    chk("rst_addr", DMEM_ADDR, 64'd0);
    chk("rst_wb_v", WB_V, 1'b0);
    chk("rst_result", WB_MEM_RESULT, 64'd0);
    chk("rst_stall", MEM_STALL, 1'b0);
    chk("rst_state", dbg_state, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    // ---- table: 1-cycle paths, never a DMEM request ----
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      MEM_V = vecs[i].v; MEM_IR = vecs[i].ir; MEM_ALU_RESULT = vecs[i].alu;
      MEM_FLUSH = vecs[i].flush; MEM_ECALL = vecs[i].ecall; MEM_F_IAF = vecs[i].f_iaf;
      #1;
      chk($sformatf("vec%0d_stall", i), MEM_STALL, 1'b0);
      @(negedge CLK);
      chk($sformatf("vec%0d_req", i), DMEM_REQ, 1'b0);
      chk($sformatf("vec%0d_wb_v", i), WB_V, vecs[i].exp_v);
      chk($sformatf("vec%0d_lam", i), WB_LAM, vecs[i].exp_lam);
      chk($sformatf("vec%0d_sam", i), WB_SAM, vecs[i].exp_sam);
      chk($sformatf("vec%0d_iaf", i), WB_F_IAF, vecs[i].f_iaf);
      chk($sformatf("vec%0d_alu", i), WB_ALU_RESULT, vecs[i].alu);
      chk($sformatf("vec%0d_result", i), WB_MEM_RESULT, 64'd0);
    end
    MEM_V = 1'b0; MEM_FLUSH = 1'b0; MEM_ECALL = 1'b0; MEM_F_IAF = 1'b0;

    // ---- LB / LBU at 0x1003, ACK 3 cycles after REQ ----
    run_txn(mk_ir(OP_LD, 3'd0), 64'h1003, 64'd0, 64'h00000000_80000000, 3, 0, 0, 0, -1, 0, 4'd0);
    chk("lb_addr", o_addr, 64'h1000);
    chk("lb_stall", 64'(o_stall), 64'd4);
    chk("lb_wb_v", WB_V, 1'b1);
    chk("lb_result", WB_MEM_RESULT, 64'hFFFFFFFF_FFFFFF80);
    run_txn(mk_ir(OP_LD, 3'd4), 64'h1003, 64'd0, 64'h00000000_80000000, 3, 0, 0, 0, -1, 0, 4'd0);
    chk("lbu_result", WB_MEM_RESULT, 64'h80);

    // ---- SH at 0x2006, immediate ACK ----
    run_txn(mk_ir(OP_ST, 3'd1), 64'h2006, 64'hBEEF, 64'd0, 0, 0, 0, 0, -1, 0, 4'd0);
    chk("sh_wstrb", o_wstrb, 8'hC0);
    chk("sh_wdata", o_wdata, 64'hBEEF0000_00000000);
    chk("sh_we", o_we, 1'b1);
    chk("sh_stall", 64'(o_stall), 64'd1);
    chk("sh_wb_v", WB_V, 1'b1);

    // ---- LD timeout, then ERR+ACK together ----
    run_txn(mk_ir(OP_LD, 3'd3), 64'h8000, 64'd0, 64'd0, 0, 0, 1, 0, -1, 0, 4'd0);
    chk("to_nreq", 64'(o_nreq), 64'(TIMEOUT));
    chk("to_laf", WB_LAF, 1'b1);
    chk("to_wb_v", WB_V, 1'b1);
    chk("to_result", WB_MEM_RESULT, 64'd0);
    run_txn(mk_ir(OP_LD, 3'd3), 64'h8008, 64'd0, 64'h1234, 1, 1, 0, 1, -1, 0, 4'd0);
    chk("err_laf", WB_LAF, 1'b1);
    chk("err_result", WB_MEM_RESULT, 64'd0);

    // ---- store flushed in WAIT: DMEM access completes, result squashed ----
    run_txn(mk_ir(OP_ST, 3'd2), 64'h9004, 64'hCAFE, 64'd0, 3, 0, 0, 0, 1, 0, 4'd0);
    chk("fl_nreq", 64'(o_nreq), 64'd4);
    chk("fl_wb_v", WB_V, 1'b0);
    chk("fl_saf", WB_SAF, 1'b0);

    // ---- async reset while waiting ----
    @(negedge CLK);
    MEM_V = 1'b1; MEM_IR = mk_ir(OP_LD, 3'd3); MEM_ALU_RESULT = 64'hA000;
    @(negedge CLK);
    chk("pre_rst_req", DMEM_REQ, 1'b1);
    #2;
    MEM_V = 1'b0; RESET = 1'b0;
    #1;
    chk("arst_req", DMEM_REQ, 1'b0);
    chk("arst_addr", DMEM_ADDR, 64'd0);
    chk("arst_wb_v", WB_V, 1'b0);
    chk("arst_stall", MEM_STALL, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    run_txn({12'd7, 5'd0, 3'd0, 5'd5, OP_AL}, 64'h7, 64'd0, 64'd0, 0, 0, 0, 0, -1, 0, 4'd0);
    chk("post_rst_wb_v", WB_V, 1'b1);
    chk("post_rst_nreq", 64'(o_nreq), 64'd0);

    // ---- randomized transactions against the model ----
    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = $urandom_range(0, 11);
      ir = $urandom;
      if (sel <= 6)       begin ir[6:0] = OP_LD; ir[14:12] = 3'(sel); end
      else if (sel <= 10) begin ir[6:0] = OP_ST; ir[14:12] = 3'(sel - 7); end
      else                      ir[6:0] = OP_AL;
      alu   = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        case (ir[13:12])
          2'd1:    alu[0] = 1'b0;
          2'd2:    alu[1:0] = 2'd0;
          2'd3:    alu[2:0] = 3'd0;
          default: ;
        endcase
      end
      sr2    = {$urandom, $urandom};
      rdata  = {$urandom, $urandom};
      delay  = $urandom_range(0, 4);
      err    = ($urandom_range(0, 9) == 0);
      noack  = !err && ($urandom_range(0, 19) == 0);
      xack   = 1'($urandom_range(0, 1));
      flags  = ($urandom_range(0, 19) == 0) ? (4'd1 << $urandom_range(0, 3)) : 4'd0;
      flush0 = ($urandom_range(0, 19) == 0);
      fa     = ($urandom_range(0, 9) == 0) ? $urandom_range(0, delay) : -1;
      e = model(ir, alu, sr2, rdata, flush0, fa >= 0, flags, delay, err, noack);
      run_txn(ir, alu, sr2, rdata, delay, err, noack, xack, fa, flush0, flags);
      chk("r_nreq", 64'(o_nreq), 64'(e.nreq));
      chk("r_stall", 64'(o_stall), 64'(e.nreq));
      if (e.access) begin
        chk("r_addr", o_addr, e.addr);
        chk("r_we", o_we, e.we);
        if (e.we) begin
          chk("r_wdata", o_wdata, e.wdata);
          chk("r_wstrb", o_wstrb, e.wstrb);
        end
      end
      chk("r_wb_v", WB_V, e.wb_v);
      chk("r_result", WB_MEM_RESULT, e.res);
      chk("r_lam", WB_LAM, e.lam);
      chk("r_sam", WB_SAM, e.sam);
      chk("r_laf", WB_LAF, e.laf);
      chk("r_saf", WB_SAF, e.saf);
      chk("r_alu", WB_ALU_RESULT, alu);
      chk("r_npc", WB_NPC, MEM_NPC);
      chk("r_drid", WB_DRID, MEM_DRID);
      chk("r_ecall", WB_ECALL, flags[3]);
      chk("r_iaf", WB_F_IAF, flags[1]);
      // Stray ACK while idle must be ignored.
      DMEM_ACK = 1'($urandom_range(0, 1));
    end

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
